// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man sprite motion controller.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam int TILE_SIZE = 32;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:   opposite = DIR_DOWN;
      DIR_DOWN: opposite = DIR_UP;
      DIR_LEFT: opposite = DIR_RIGHT;
      default:  opposite = DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/pacman_mover_frame_tick_det.sv
// Rising-edge detector on the vsync level; tick is high for exactly one Clk per frame.
module frame_tick_det (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_clk,
  output logic tick
);

  logic frame_clk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_clk_d <= 1'b0;
    else        frame_clk_d <= frame_clk;
  end

  assign tick = frame_clk & ~frame_clk_d;

endmodule

// File: rtl/pacman_mover.sv
// Grid-locked Pac-Man motion controller: one step per frame tick, turns only on tile alignment.
// PACMAN_TURN_BUFFER_EN: when defined, key requests are latched until feasible; otherwise the key must be held.
module pacman_mover
  import pacman_pkg::*;
#(
  parameter logic [9:0] STEP    = 10'd2,
  parameter logic [9:0] START_X = 10'd32,
  parameter logic [9:0] START_Y = 10'd32
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       is_wall_up,
  input  logic       is_wall_down,
  input  logic       is_wall_left,
  input  logic       is_wall_right,
  output logic [9:0] Ball_X_Pos_out,
  output logic [9:0] Ball_Y_Pos_out,
  output dir_t       dir,
  output logic       moving
);

  localparam int ALIGN_BITS = $clog2(TILE_SIZE);

  logic   tick;
  logic   key_valid;
  dir_t   key_dir;
  logic   req_valid;
  dir_t   req_dir;
  logic   take;
  logic   step;
  logic   aligned;
  state_t state;
  state_t nxt_state;
  dir_t   nxt_dir;

  frame_tick_det u_tick (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  function automatic logic wall_of(input dir_t d);
    case (d)
      DIR_UP:   wall_of = is_wall_up;
      DIR_DOWN: wall_of = is_wall_down;
      DIR_LEFT: wall_of = is_wall_left;
      default:  wall_of = is_wall_right;
    endcase
  endfunction

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_RIGHT;
    case (keycode)
      KEY_W:   key_dir = DIR_UP;
      KEY_S:   key_dir = DIR_DOWN;
      KEY_A:   key_dir = DIR_LEFT;
      KEY_D:   key_dir = DIR_RIGHT;
      default: key_valid = 1'b0;
    endcase
  end

`ifdef PACMAN_TURN_BUFFER_EN
  // A key landing on the same edge as a consuming tick wins, so it is kept for the next tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      req_valid <= 1'b0;
      req_dir   <= DIR_RIGHT;
    end else begin
      if (tick && take) req_valid <= 1'b0;
      if (key_valid) begin
        req_valid <= 1'b1;
        req_dir   <= key_dir;
      end
    end
  end
`else
  assign req_valid = key_valid;
  assign req_dir   = key_dir;
`endif

  assign aligned = (Ball_X_Pos_out[ALIGN_BITS-1:0] == '0) &&
                   (Ball_Y_Pos_out[ALIGN_BITS-1:0] == '0);

  // Off-alignment the wall flags are forced high, so only a reversal is considered there.
  always_comb begin
    take      = 1'b0;
    step      = 1'b0;
    nxt_state = state;
    case (state)
      IDLE: begin
        if (req_valid && !wall_of(req_dir)) begin
          take      = 1'b1;
          step      = 1'b1;
          nxt_state = MOVING;
        end
      end
      default: begin
        if (aligned) begin
          if (req_valid && !wall_of(req_dir)) begin
            take = 1'b1;
            step = 1'b1;
          end else if (!wall_of(dir)) begin
            step = 1'b1;
          end else begin
            nxt_state = IDLE;
          end
        end else begin
          take = req_valid && (req_dir == opposite(dir));
          step = 1'b1;
        end
      end
    endcase
  end

  assign nxt_dir = take ? req_dir : dir;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      dir            <= DIR_RIGHT;
      moving         <= 1'b0;
      Ball_X_Pos_out <= START_X;
      Ball_Y_Pos_out <= START_Y;
    end else if (tick) begin
      state  <= nxt_state;
      dir    <= nxt_dir;
      moving <= (nxt_state == MOVING);
      if (step) begin
        case (nxt_dir)
          DIR_UP:   Ball_Y_Pos_out <= Ball_Y_Pos_out - STEP;
          DIR_DOWN: Ball_Y_Pos_out <= Ball_Y_Pos_out + STEP;
          DIR_LEFT: Ball_X_Pos_out <= Ball_X_Pos_out - STEP;
          default:  Ball_X_Pos_out <= Ball_X_Pos_out + STEP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover with a simple maze model driving the wall flags.
module tb_pacman_mover;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [3:0] maze;   // {up, down, left, right} flags used when the sprite is tile-aligned
  logic [9:0] x;
  logic [9:0] y;
  logic [1:0] dir;
  logic       moving;
  logic       aligned_tb;
  logic       wall_up, wall_down, wall_left, wall_right;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign aligned_tb = (x[4:0] == 5'd0) && (y[4:0] == 5'd0);
  assign wall_up    = aligned_tb ? maze[3] : 1'b1;
  assign wall_down  = aligned_tb ? maze[2] : 1'b1;
  assign wall_left  = aligned_tb ? maze[1] : 1'b1;
  assign wall_right = aligned_tb ? maze[0] : 1'b1;

  pacman_mover dut (
    .Clk            (clk),
    .Reset_n        (rst_n),
    .frame_clk      (frame_clk),
    .keycode        (keycode),
    .is_wall_up     (wall_up),
    .is_wall_down   (wall_down),
    .is_wall_left   (wall_left),
    .is_wall_right  (wall_right),
    .Ball_X_Pos_out (x),
    .Ball_Y_Pos_out (y),
    .dir            (dir),
    .moving         (moving)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // frame_clk stays high for several Clk cycles; only its rising edge counts.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_clk = 1'b1;
      repeat (3) @(negedge clk);
      frame_clk = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic press(input logic [7:0] k);
    @(negedge clk) keycode = k;
    @(negedge clk) keycode = 8'h00;
  endtask

  initial begin
    rst_n     = 1'b0;
    frame_clk = 1'b0;
    keycode   = 8'h00;
    maze      = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_x", x, 32);
    check("rst_y", y, 32);
    check("rst_dir", dir, 3);
    check("rst_moving", moving, 0);
    rst_n = 1'b1;

    ticks(5);
    check("idle5_x", x, 32);
    check("idle5_y", y, 32);
    check("idle5_moving", moving, 0);
    check("idle5_dir", dir, 3);

    // D tapped for one Clk, then a frame tick
    press(8'h07);
    ticks(1);
`ifdef PACMAN_TURN_BUFFER_EN
    check("start_x", x, 34);
    check("start_moving", moving, 1);
`else
    check("unbuf_tap_x", x, 32);
    check("unbuf_tap_moving", moving, 0);
    keycode = 8'h07;
    ticks(1);
    keycode = 8'h00;
    check("start_x", x, 34);
    check("start_moving", moving, 1);
`endif
    check("start_dir", dir, 3);
    ticks(15);
    check("tile64_x", x, 64);
    check("tile64_y", y, 32);

    // S held while the down neighbour is walled: keeps going right
    maze    = 4'b0100;
    keycode = 8'h16;
    ticks(1);
    check("sblk_x", x, 66);
    check("sblk_y", y, 32);
    check("sblk_dir", dir, 3);
    ticks(15);
    check("tile96_x", x, 96);
    maze = 4'b0000;
    ticks(1);
    keycode = 8'h00;
    check("turn_dir", dir, 1);
    check("turn_x", x, 96);
    check("turn_y", y, 34);

    // A tapped (pending under buffering), then reset mid-move
    press(8'h04);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("arst_x", x, 32);
    check("arst_y", y, 32);
    check("arst_moving", moving, 0);
    check("arst_dir", dir, 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ticks(1);
    check("postrst_x", x, 32);
    check("postrst_moving", moving, 0);

    // Reversal mid-tile
    keycode = 8'h07;
    ticks(1);
    keycode = 8'h00;
    check("run_x", x, 34);
    ticks(3);
    check("at40_x", x, 40);
    keycode = 8'h04;
    ticks(1);
    keycode = 8'h00;
    check("rev_x", x, 38);
    check("rev_dir", dir, 2);
    ticks(1);
    check("left36_x", x, 36);
    keycode = 8'h07;
    ticks(1);
    keycode = 8'h00;
    check("rev2_x", x, 38);
    check("rev2_dir", dir, 3);
    ticks(45);
    check("at128_x", x, 128);
    check("at128_moving", moving, 1);

    // Right wall at (128,32) with nothing requested: stop
    maze = 4'b0001;
    ticks(1);
    check("stop_x", x, 128);
    check("stop_moving", moving, 0);
    check("stop_dir", dir, 3);
    ticks(1);
    check("frozen_x", x, 128);

    // Request blocked by the wall, then the wall opens
    press(8'h07);
    ticks(1);
    check("blk_x", x, 128);
    check("blk_moving", moving, 0);
    maze = 4'b0000;
    ticks(1);
`ifdef PACMAN_TURN_BUFFER_EN
    check("held_x", x, 130);
    check("held_moving", moving, 1);
`else
    check("nohold_x", x, 128);
    keycode = 8'h07;
    ticks(1);
    keycode = 8'h00;
    check("held_x", x, 130);
    check("held_moving", moving, 1);
`endif
    check("held_y", y, 32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
